// File: rtl/fixed_lut_activation_loader.sv
// Runtime-programmable lookup-table activation: a stream fills the per-lane
// tables, then indices are looked up with a one-stage registered read.
module fixed_lut_activation_loader #(
    parameter int unsigned DATA_IN_0_PRECISION_0       = 8,
    parameter int unsigned DATA_IN_0_PRECISION_1       = 4,
    parameter int unsigned DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int unsigned DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int unsigned DATA_OUT_0_PRECISION_0      = 8,
    parameter int unsigned DATA_OUT_0_PRECISION_1      = 4
) (
    input  logic clk,
    input  logic rst,

    input  logic [DATA_OUT_0_PRECISION_0-1:0] lut_data_in,
    input  logic                              lut_data_in_valid,
    output logic                              lut_data_in_ready,
    input  logic                              lut_reload,
    output logic                              lut_loaded,

    input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
    input  logic                                                                                       data_in_0_valid,
    output logic                                                                                       data_in_0_ready,

    output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic                                                                                       data_out_0_valid,
    input  logic                                                                                       data_out_0_ready
);

    localparam int unsigned P     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int unsigned IW    = DATA_IN_0_PRECISION_0;
    localparam int unsigned OW    = DATA_OUT_0_PRECISION_0;
    localparam int unsigned DEPTH = 2 ** IW;

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] wr_addr_q, wr_addr_d;
    logic          out_valid_q;
    logic          lut_hs;
    logic          in_hs;

    assign lut_data_in_ready = (state_q == LOAD) && !rst;
    assign data_in_0_ready   = (state_q == RUN) && !rst && (!out_valid_q || data_out_0_ready);
    assign lut_loaded        = (state_q == RUN);
    assign data_out_0_valid  = out_valid_q;

    assign lut_hs = lut_data_in_valid && lut_data_in_ready;
    assign in_hs  = data_in_0_valid && data_in_0_ready;

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        unique case (state_q)
            LOAD: begin
                if (lut_hs) begin
                    // Incrementing past the last entry wraps the address to zero.
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (wr_addr_q == '1) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (lut_reload) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid_q) begin
                    state_d   = LOAD;
                    wr_addr_d = '0;
                end
            end
            default: begin
                state_d   = LOAD;
                wr_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            wr_addr_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            if (in_hs) begin
                out_valid_q <= 1'b1;
            end else if (data_out_0_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Fraction widths only describe the Q format; one wider than its word leaves the datapath unbuilt.
    if (DATA_IN_0_PRECISION_1 <= DATA_IN_0_PRECISION_0 &&
        DATA_OUT_0_PRECISION_1 <= DATA_OUT_0_PRECISION_0) begin : g_datapath
        for (genvar l = 0; l < P; l++) begin : g_lane
            logic [OW-1:0] lut_mem [DEPTH];
            logic [IW-1:0] rd_addr;
            logic [OW-1:0] out_q;

            assign rd_addr = data_in_0[l*IW +: IW];
            assign data_out_0[l*OW +: OW] = out_q;

            // Table contents survive reset; only a full reload makes them valid again.
            always_ff @(posedge clk) begin
                if (lut_hs) begin
                    lut_mem[wr_addr_q] <= lut_data_in;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_q <= '0;
                end else if (in_hs) begin
                    out_q <= lut_mem[rd_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_fixed_lut_activation_loader.sv
// Directed bench for fixed_lut_activation_loader with a 4-lane datapath and a
// queue scoreboard fed from the bench's own copy of the table.
module tb_fixed_lut_activation_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  lut_data_in;
    logic        lut_data_in_valid;
    logic        lut_data_in_ready;
    logic        lut_reload;
    logic        lut_loaded;
    logic [31:0] data_in_0;
    logic        data_in_0_valid;
    logic        data_in_0_ready;
    logic [31:0] data_out_0;
    logic        data_out_0_valid;
    logic        data_out_0_ready;

    fixed_lut_activation_loader #(
        .DATA_IN_0_PRECISION_0      (8),
        .DATA_IN_0_PRECISION_1      (4),
        .DATA_IN_0_PARALLELISM_DIM_0(2),
        .DATA_IN_0_PARALLELISM_DIM_1(2),
        .DATA_OUT_0_PRECISION_0     (8),
        .DATA_OUT_0_PRECISION_1     (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .lut_data_in      (lut_data_in),
        .lut_data_in_valid(lut_data_in_valid),
        .lut_data_in_ready(lut_data_in_ready),
        .lut_reload       (lut_reload),
        .lut_loaded       (lut_loaded),
        .data_in_0        (data_in_0),
        .data_in_0_valid  (data_in_0_valid),
        .data_in_0_ready  (data_in_0_ready),
        .data_out_0       (data_out_0),
        .data_out_0_valid (data_out_0_valid),
        .data_out_0_ready (data_out_0_ready)
    );

    always #5 clk = ~clk;

    logic [7:0]  ref_tab [256];
    logic [31:0] exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_rx  = 0;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_data;
    bit          last_in_hs;
    bit          last_lut_hs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    function automatic logic [7:0] entry(input int kind, input int a);
        logic [7:0] a8;
        a8 = 8'(a);
        case (kind)
            0:       return ~a8;
            1:       return a8;
            default: return 8'(a * 7 + 3);
        endcase
    endfunction

    function automatic logic [31:0] model(input logic [31:0] idx);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) r[l*8 +: 8] = ref_tab[idx[l*8 +: 8]];
        return r;
    endfunction

    // Samples handshakes just before the edge, then advances one cycle.
    task automatic tick();
        #1;
        last_in_hs  = 1'b0;
        last_lut_hs = 1'b0;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", data_out_0_valid, 1);
                chk("stall_data", data_out_0, prev_data);
            end
            if (data_out_0_valid && data_out_0_ready) begin
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("sb_data", data_out_0, exp_q.pop_front());
                n_rx++;
            end
            if (data_in_0_valid && data_in_0_ready) begin
                exp_q.push_back(model(data_in_0));
                last_in_hs = 1'b1;
            end
            last_lut_hs = lut_data_in_valid && lut_data_in_ready;
            stall_prev  = data_out_0_valid && !data_out_0_ready;
            prev_data   = data_out_0;
        end
        @(negedge clk);
    endtask

    task automatic load_table(input int kind, input int n, input int gap_pct, input bit chk_in);
        int guard;
        for (int a = 0; a < n; a++) begin
            guard = 0;
            lut_data_in = entry(kind, a);
            if (chk_in) lut_reload = (a < 255);
            do begin
                lut_data_in_valid = ($urandom_range(99) >= gap_pct);
                #1;
                chk("loaded_low_during_load", lut_loaded, 0);
                if (chk_in) chk("in_ready_during_load", data_in_0_ready, 0);
                tick();
                guard++;
            end while (!last_lut_hs && guard < 200);
            if (!last_lut_hs) begin
                chk("lut_ready_timeout", lut_data_in_ready, 1);
                summary();
                $fatal(1, "lut load stalled");
            end
            ref_tab[a] = entry(kind, a);
        end
        lut_data_in_valid = 1'b0;
        lut_reload        = 1'b0;
    endtask

    task automatic do_lookup(input string tag, input logic [31:0] idx, input logic [31:0] expv);
        int guard;
        guard = 0;
        data_out_0_ready = 1'b1;
        data_in_0        = idx;
        data_in_0_valid  = 1'b1;
        do begin
            tick();
            guard++;
        end while (!last_in_hs && guard < 20);
        data_in_0_valid = 1'b0;
        chk({tag, "_accepted"}, last_in_hs, 1);
        #1;
        chk({tag, "_valid"}, data_out_0_valid, 1);
        chk(tag, data_out_0, expv);
        tick();
        #1;
        chk({tag, "_valid_drop"}, data_out_0_valid, 0);
    endtask

    task automatic reload_idle();
        int guard;
        guard = 0;
        lut_reload = 1'b1;
        tick();
        lut_reload = 1'b0;
        #1;
        while (!lut_data_in_ready && guard < 10) begin
            tick();
            #1;
            guard++;
        end
        chk("reload_to_load", lut_data_in_ready, 1);
    endtask

    initial begin
        int sent;
        int cyc;
        int rx0;
        rst               = 1'b1;
        lut_data_in       = '0;
        lut_data_in_valid = 1'b0;
        lut_reload        = 1'b0;
        data_in_0         = '0;
        data_in_0_valid   = 1'b0;
        data_out_0_ready  = 1'b0;
        @(negedge clk);
        tick();
        tick();
        #1;
        chk("rst_loaded", lut_loaded, 0);
        chk("rst_lut_ready", lut_data_in_ready, 0);
        chk("rst_out_valid", data_out_0_valid, 0);
        chk("rst_out_data", data_out_0, 0);
        chk("rst_in_ready", data_in_0_ready, 0);
        rst = 1'b0;
        #1;
        chk("load_ready_after_rst", lut_data_in_ready, 1);

        // 1: gap-free load of ~i, single lookup with latency check
        load_table(0, 256, 0, 1'b0);
        #1;
        chk("loaded_after_last", lut_loaded, 1);
        chk("lut_ready_in_run", lut_data_in_ready, 0);
        data_out_0_ready = 1'b1;
        data_in_0        = 32'h05050505;
        data_in_0_valid  = 1'b1;
        #1;
        chk("in_ready_run", data_in_0_ready, 1);
        tick();
        data_in_0_valid = 1'b0;
        #1;
        chk("latency1_valid", data_out_0_valid, 1);
        chk("latency1_data", data_out_0, 32'hFAFAFAFA);
        tick();

        // 2: reload, gapped load with lookups requested and reload held high
        reload_idle();
        data_in_0       = 32'h11223344;
        data_in_0_valid = 1'b1;
        load_table(0, 256, 40, 1'b1);
        #1;
        chk("loaded_after_gaps", lut_loaded, 1);
        chk("in_ready_after_load", data_in_0_ready, 1);
        data_in_0_valid = 1'b0;
        do_lookup("edge_idx", 32'hFF7F0080, 32'h0080FF7F);

        // 3: 500 beats under random backpressure, then full rate
        sent = 0;
        cyc  = 0;
        rx0  = n_rx;
        while ((sent < 500 || exp_q.size() != 0) && cyc < 5000) begin
            data_out_0_ready = 1'($urandom_range(1));
            data_in_0_valid  = (sent < 500) && ($urandom_range(3) != 0);
            data_in_0        = $urandom;
            tick();
            if (last_in_hs) sent++;
            cyc++;
        end
        data_in_0_valid = 1'b0;
        chk("burst_sent", sent, 500);
        chk("burst_rx", n_rx - rx0, 500);
        chk("burst_sb_empty", exp_q.size(), 0);
        data_out_0_ready = 1'b1;
        data_in_0_valid  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            data_in_0 = $urandom;
            tick();
            chk("full_rate", last_in_hs, 1);
        end
        data_in_0_valid = 1'b0;
        tick();
        chk("full_rate_drained", exp_q.size(), 0);

        // 4: reload with a stalled beat pending
        data_out_0_ready = 1'b0;
        data_in_0        = 32'h10203040;
        data_in_0_valid  = 1'b1;
        lut_reload       = 1'b1;
        tick();
        chk("drain_beat_taken", last_in_hs, 1);
        lut_reload = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("drain_loaded", lut_loaded, 0);
            chk("drain_in_ready", data_in_0_ready, 0);
            chk("drain_valid", data_out_0_valid, 1);
            chk("drain_data", data_out_0, 32'hEFDFCFBF);
            tick();
        end
        data_in_0_valid  = 1'b0;
        data_out_0_ready = 1'b1;
        tick();
        #1;
        chk("drain_done_valid", data_out_0_valid, 0);
        chk("drain_not_load_yet", lut_data_in_ready, 0);
        tick();
        #1;
        chk("drain_to_load", lut_data_in_ready, 1);
        chk("drain_sb_empty", exp_q.size(), 0);
        load_table(1, 256, 20, 1'b0);
        do_lookup("identity_33", 32'h33333333, 32'h33333333);

        // 5: reset mid-load, then a fresh full load
        reload_idle();
        load_table(2, 100, 0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_loaded", lut_loaded, 0);
        chk("midrst_lut_ready", lut_data_in_ready, 0);
        tick();
        #1;
        chk("midrst_lut_ready2", lut_data_in_ready, 0);
        chk("midrst_out_valid", data_out_0_valid, 0);
        chk("midrst_out_data", data_out_0, 0);
        rst = 1'b0;
        #1;
        chk("postrst_lut_ready", lut_data_in_ready, 1);
        load_table(2, 256, 20, 1'b0);
        #1;
        chk("reloaded", lut_loaded, 1);
        do_lookup("fresh_load", 32'hFF646300, 32'hFCBFB803);

        summary();
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        summary();
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fixed_lut_activation_loader.md
Name: fixed_lut_activation_loader

Overview:
- Runtime-programmable lookup-table activation unit. It is the writer side of the table-lookup activation path: it fills the table from a stream instead of a build-time memory file, then serves lookups.
- Sits between an upstream config/DMA stream and the activation stage of a MASE dataflow pipeline.
- Any pointwise fixed-point activation (ELU, GELU, sigmoid, ...) can be swapped without resynthesis.

Parameters:
- DATA_IN_0_PRECISION_0, 8, input word width; table depth is 2**DATA_IN_0_PRECISION_0.
- DATA_IN_0_PRECISION_1, 4, input fractional bits (informational only, no arithmetic).
- DATA_IN_0_PARALLELISM_DIM_0, 1, lanes per beat, dim 0.
- DATA_IN_0_PARALLELISM_DIM_1, 1, lanes per beat, dim 1; P = DIM_0*DIM_1.
- DATA_OUT_0_PRECISION_0, 8, table entry / output width.
- DATA_OUT_0_PRECISION_1, 4, output fractional bits (informational only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- lut_data_in  in  DATA_OUT_0_PRECISION_0  table entry stream, sent in address order 0..2**DATA_IN_0_PRECISION_0-1.
- lut_data_in_valid  in  1  entry valid.
- lut_data_in_ready  out  1  entry accepted when valid&&ready.
- lut_reload  in  1  level request to reprogram the table.
- lut_loaded  out  1  table complete, lookups enabled.
- data_in_0  in  P x DATA_IN_0_PRECISION_0  lookup indices (two's-complement bit pattern used as an unsigned address).
- data_in_0_valid  in  1
- data_in_0_ready  out  1
- data_out_0  out  P x DATA_OUT_0_PRECISION_0  looked-up values.
- data_out_0_valid  out  1
- data_out_0_ready  in  1

Behaviour:
- Storage: one table copy per lane, each 2**DATA_IN_0_PRECISION_0 deep. Every write goes to all copies at the same address.
- FSM states: LOAD, RUN, DRAIN.
- Reset values: state=LOAD, wr_addr=0, lut_loaded=0, data_out_0_valid=0, data_out_0=0, lut_data_in_ready=0 in the reset cycle. Table contents are not cleared.

LOAD state:
- lut_data_in_ready=1 and data_in_0_ready=0.
- Each lut handshake writes table[wr_addr] and then increments wr_addr.
- Gaps in lut_data_in_valid are allowed; wr_addr holds during a gap.
- A handshake at wr_addr = 2**N-1 writes the last entry. Next cycle: state=RUN, lut_loaded=1, wr_addr wraps to 0.

RUN state:
- lut_data_in_ready=0.
- One-stage registered lookup: data_in_0_ready = !data_out_0_valid || data_out_0_ready.
- On an input handshake, data_out_0[i] <= table_i[data_in_0[i]] and data_out_0_valid <= 1 on the next edge. Latency is 1 cycle and throughput is 1 beat per cycle.
- Output held stable while valid && !ready. Valid drops after an output handshake with no new input accepted in the same cycle.
- Index is an unsigned bit pattern: 0x80 (-8.0 in Q4.4) reads entry 128; 0xFF reads entry 255.

Reload:
- lut_reload=1 in RUN moves to DRAIN on the next edge. The input beat accepted in that same cycle (if any) still completes.
- DRAIN: data_in_0_ready=0, lut_loaded=0, and the pending output beat is still delivered under normal backpressure.
- When data_out_0_valid=0 in DRAIN: state=LOAD, wr_addr=0.
- lut_reload is ignored in LOAD and DRAIN.

Other rules:
- A lookup write and a table read never occur in the same cycle, because load and lookup are exclusive by state.
- rst in any state (mid-load or with an output beat pending) aborts the operation and returns to reset values. Partial table data remains but is invalid until a full reload.

Test Plan:
1. Reset, then stream 256 entries table[i]=~i with no gaps; drive data_in_0=0x05 -> lut_loaded=1 one cycle after the 256th handshake; data_out_0=0xFA exactly 1 cycle after acceptance.
2. Stream entries with random valid gaps, and drive data_in_0_valid=1 throughout load -> data_in_0_ready stays 0 until lut_loaded; no entry is skipped (check 0x00->0xFF, 0x7F->0x80, 0xFF->0x00).
3. RUN with data_out_0_ready toggling randomly over 500 beats, P=4 -> no lost or duplicated beats; order preserved; output stable while stalled; full 1 beat/cycle when ready is held high.
4. Pulse lut_reload with an output beat pending and ready=0 for 5 cycles -> beat delivered intact, then LOAD; reload table[i]=i; lookup 0x33 -> 0x33.
5. Assert rst after 100 load entries -> lut_loaded=0, lut_data_in_ready=0 during reset; a fresh full load completes correctly.
